// File: rtl/seg7_page_scan.sv
// seg7_page_scan: debug-display page sequencer for a 4-digit 7-segment stage.
// Captures a coherent 64-bit snapshot of iVAL and shows one 16-bit page at a time.
// Pages advance on a debounced pushbutton press or on an optional auto-advance tick.
//
// Ports:
//   iCLK    system clock, all state on the rising edge
//   iRST_N  synchronous active-low reset
//   iVAL    64-bit debug value, sampled only when the snapshot loads
//   iKEY_N  raw active-low pushbutton (asynchronous, bouncing)
//   iAUTO   auto-advance enable (level)
//   oDIG    current page of the snapshot, snapshot[16p+15:16p]
//   oPAGE   current page index
//   oFIRST  high when oPAGE == 0
//   oBLANK  bit k high -> digit oDIG[4k+3:4k] is a leading zero
module seg7_page_scan #(
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned AUTO_CYCLES = 50000000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [63:0] iVAL,
  input  logic        iKEY_N,
  input  logic        iAUTO,
  output logic [15:0] oDIG,
  output logic [1:0]  oPAGE,
  output logic        oFIRST,
  output logic [3:0]  oBLANK
);

  localparam int unsigned DebW  = $clog2(DEB_CYCLES);
  localparam int unsigned AutoW = $clog2(AUTO_CYCLES);

  logic             key_meta_q, key_sync_q;
  logic             key_db_q, key_db_d;
  logic             key_db_dly_q;
  logic             press_q, press_d;
  logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [AutoW-1:0] timer_q, timer_d;
  logic [1:0]       page_q, page_d;
  logic [63:0]      snap_q, snap_d;
  logic             load_pend_q;
  logic [15:0]      dig_q, dig_d;
  logic [1:0]       page_out_q;
  logic             first_q;
  logic [3:0]       blank_q, blank_d;

  logic             tick;
  logic             step;
  logic [15:0]      blank_all;
  logic             all_zero;

  always_comb begin
    // Debouncer: key_db only follows the synchronized key after DEB_CYCLES of disagreement.
    key_db_d  = key_db_q;
    deb_cnt_d = '0;
    if (key_sync_q != key_db_q) begin
      if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
        key_db_d = key_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    press_d = key_db_dly_q & ~key_db_q;

    tick = iAUTO && (timer_q == AutoW'(AUTO_CYCLES - 1));
    step = press_q | tick;

    // A press restarts the period so the next tick is a full period away.
    if (!iAUTO || press_q || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    page_d = step ? page_q + 2'd1 : page_q;

    // Snapshot only changes at the start of a sweep, keeping all four pages coherent.
    snap_d = snap_q;
    if (load_pend_q || (step && (page_q == 2'd3))) begin
      snap_d = iVAL;
    end

    // Scan from the top digit down; a digit is blank while everything above it is zero.
    blank_all = '0;
    all_zero  = 1'b1;
    for (int n = 15; n >= 0; n--) begin
      all_zero     = all_zero & (snap_q[4*n +: 4] == 4'h0);
      blank_all[n] = all_zero;
    end
    blank_all[0] = 1'b0;

    dig_d   = snap_q[16*page_q +: 16];
    blank_d = blank_all[4*page_q +: 4];
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      key_meta_q   <= 1'b1;
      key_sync_q   <= 1'b1;
      key_db_q     <= 1'b1;
      key_db_dly_q <= 1'b1;
      deb_cnt_q    <= '0;
      press_q      <= 1'b0;
      timer_q      <= '0;
      page_q       <= 2'd0;
      snap_q       <= '0;
      load_pend_q  <= 1'b1;
      dig_q        <= 16'h0000;
      page_out_q   <= 2'd0;
      first_q      <= 1'b1;
      blank_q      <= 4'b1110;
    end else begin
      key_meta_q   <= iKEY_N;
      key_sync_q   <= key_meta_q;
      key_db_q     <= key_db_d;
      key_db_dly_q <= key_db_q;
      deb_cnt_q    <= deb_cnt_d;
      press_q      <= press_d;
      timer_q      <= timer_d;
      page_q       <= page_d;
      snap_q       <= snap_d;
      load_pend_q  <= 1'b0;
      dig_q        <= dig_d;
      page_out_q   <= page_q;
      first_q      <= (page_q == 2'd0);
      blank_q      <= blank_d;
    end
  end

  assign oDIG   = dig_q;
  assign oPAGE  = page_out_q;
  assign oFIRST = first_q;
  assign oBLANK = blank_q;

endmodule
